multiplane_tilemap_renderer: RTL and testbench
==============================================

MULTIPLANE_TILEMAP_RENDERER -- requirements
Module: multiplane_tilemap_renderer

Interface
REQ-001 SHALL have these parameters (name, default, meaning):
- NUM_PLANES 2: tilemap planes.
- ADDR_PINS 4 / DATA_PINS 4: serial RAM pins.
- RAM_LOG2_CYCLES 2: clocks per transaction = 2^RAM_LOG2_CYCLES.
- TRANS_DELAY 2: transactions from address to data.
- LOG2_TILESIZE 3: tile width and height = 2^LOG2_TILESIZE.
- COLOR_BITS 2: bits per pixel.
- TMAP_X_BITS 6 / TMAP_Y_BITS 5: tilemap dimensions.
- Y_BITS 8: line counter width.
- LINE_TILES 40: tile columns per line.
REQ-002 SHALL have these ports (name, direction, width, meaning), clock and reset first:
- clk, in, 1: single clock.
- reset, in, 1: synchronous, active-high.
- line_start, in, 1: start-of-line pulse.
- y, in, Y_BITS: current line.
- scroll_x, in, NUM_PLANES*TMAP_X_BITS: coarse x scroll per plane, in tiles.
- scroll_y, in, NUM_PLANES*Y_BITS: y scroll per plane, in lines.
- map_base, in, NUM_PLANES*MB: map base per plane, where MB = AW-TMAP_X_BITS-TMAP_Y_BITS.
- addr_bits, out, ADDR_PINS: serial RAM address.
- data_bits, in, DATA_PINS: serial RAM data.
- pixel_out, out, NUM_PLANES*COLOR_BITS: pixel.
- pixel_valid, out, 1: pixel_out valid.
REQ-003 SHALL use AW = ADDR_PINS*2^RAM_LOG2_CYCLES and DW = DATA_PINS*2^RAM_LOG2_CYCLES; elaboration SHALL fail unless DW == 2^LOG2_TILESIZE*COLOR_BITS and 2*NUM_PLANES+2*TRANS_DELAY <= 2^LOG2_TILESIZE.

Function
REQ-004 SHALL define timing from line_start sampled high at edge T:
- subcycle k (0..RC-1) of slot s (0..TS-1) of tile period c SHALL occupy the clock following edge T+1+(c*TS+s)*RC+k.
- RC = clocks per transaction; TS = tile size.
REQ-005 SHALL shift addresses and data least-significant nibble first: subcycle k carries bits [k*PINS +: PINS].
REQ-006 SHALL treat data_bits during slot s as the response to the transaction issued in slot s-TRANS_DELAY of the same period.
REQ-007 SHALL, for plane p in period c (c < LINE_TILES), issue the map read in slot p.
- address = {map_base[p], ty, tx}.
- tx = (c + scroll_x[p]) mod 2^TMAP_X_BITS.
- v = (y + scroll_y[p]) mod 2^Y_BITS; ty = v>>LOG2_TILESIZE mod 2^TMAP_Y_BITS.
REQ-008 SHALL capture the returned tile id (low AW-LOG2_TILESIZE bits) in slot p+TRANS_DELAY.
REQ-009 SHALL issue the tile read in slot NUM_PLANES+TRANS_DELAY+p.
- address = {tile_id, v[LOG2_TILESIZE-1:0]}.
- the returned DW-bit row SHALL be captured in slot NUM_PLANES+2*TRANS_DELAY+p.
REQ-010 SHALL drive addr_bits = 0 in unused slots and when not fetching.
REQ-011 SHALL copy all fetched rows to shadow rows at the end of each period.
- During period c+1, slot i SHALL display pixel i = shadow[p][i*COLOR_BITS +: COLOR_BITS].
- pixel_out is registered and updates on the edge that starts each slot.
REQ-012 SHALL use states IDLE -> FETCH (period 0, pixel_valid=0) -> RUN (periods 1..LINE_TILES-1, fetch and display) -> DRAIN (period LINE_TILES, display only) -> IDLE.
REQ-013 SHALL hold pixel_valid = 1 exactly during RUN and DRAIN slots.
REQ-014 SHALL, on line_start in any non-IDLE state, abort the current line and restart at period 0 per REQ-004, discarding partial rows.
REQ-015 SHALL let tx wrap modulo 2^TMAP_X_BITS and v wrap modulo 2^Y_BITS without error.

Reset
REQ-016 SHALL, on reset, enter IDLE and clear counters, tile ids, and fetched and shadow rows.
- Outputs: addr_bits = 0, pixel_out = 0, pixel_valid = 0.
- Reset SHALL take priority over a simultaneous line_start.
REQ-017 SHALL, on reset asserted mid-line, abandon the line with no further RAM addresses issued.

Configuration
REQ-018 SHALL implement macro MULTIPLANE_TILEMAP_TRANSPARENCY_EN.
- Defined: color 0 is transparent; the lowest-numbered plane with nonzero color wins.
  - pixel_out = {zeros, plane index (clog2(NUM_PLANES) bits), color}.
  - All planes transparent gives 0.
- Undefined: no compositing; pixel_out = {plane NUM_PLANES-1 color, ..., plane 0 color}.

Verification (defaults, AW = 16, MB = 5)
REQ-019 Reset held 3 clocks while line_start pulses -> addr_bits = 0, pixel_out = 0, pixel_valid = 0; no fetch starts.
REQ-020 line_start, y = 0, scrolls 0, map_base = {1, 0} -> slot 0 nibbles 0,0,0,0; slot 1 (address 0x0800) nibbles 0,0,8,0.
REQ-021 RAM returns tile id 0x0005 for plane 0 in slot 2, y = 0 -> slot 4 tile address 0x0028, nibbles 8,2,0,0.
REQ-022 Plane 0 row 0x0000, plane 1 row 0xFFFF -> period 1, every slot: pixel_out = 4'b0111 with macro; 4'b1100 without; pixel_valid = 1.
REQ-023 scroll_x[0] = 63 -> period 0 tx = 63, period 1 tx = 0; scroll_y[0] = 255 with y = 1 -> ty = 0, row 0.
REQ-024 line_start re-asserted in period 5 -> next edge restarts at period 0; pixel_valid = 0 for one tile period, then pixels from new fetches; drains to IDLE after period 40.

Source files
------------

// File: rtl/multiplane_tilemap_renderer_if.sv
// Bus bundle for the multiplane tilemap renderer.
//   addr_bits   : renderer -> serial RAM, address nibble of the current subcycle
//   data_bits   : serial RAM -> renderer, data nibble of the current subcycle
//   pixel_out   : renderer -> display, registered pixel
//   pixel_valid : renderer -> display, pixel_out carries a displayed pixel
// Modports: master = renderer side, slave = RAM/display side.
interface multiplane_tilemap_renderer_if #(
    parameter int ADDR_PINS = 4,
    parameter int DATA_PINS = 4,
    parameter int PIX_W     = 4
);
    logic [ADDR_PINS-1:0] addr_bits;
    logic [DATA_PINS-1:0] data_bits;
    logic [PIX_W-1:0]     pixel_out;
    logic                 pixel_valid;

    modport master (output addr_bits, output pixel_out, output pixel_valid, input data_bits);
    modport slave  (input addr_bits, input pixel_out, input pixel_valid, output data_bits);
endinterface

// File: rtl/multiplane_tilemap_renderer.sv
// Multiplane tilemap renderer: per line, fetches map entries and tile rows
// for every plane over a nibble-serial RAM and streams composited pixels.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   line_start, y         : start-of-line pulse and current line
//   scroll_x/scroll_y     : per-plane scroll (tiles / lines)
//   map_base              : per-plane map base (upper address bits)
//   bus (master)          : addr_bits, data_bits, pixel_out, pixel_valid
// Build option: define MULTIPLANE_TILEMAP_TRANSPARENCY_EN for color-0
// transparency with priority to the lowest plane; otherwise the plane
// colors are concatenated.
//
// state | meaning
// IDLE  | no line in progress, RAM address held at 0
// FETCH | period 0: fetch only, nothing displayed
// RUN   | periods 1..LINE_TILES-1: fetch next tile, display previous
// DRAIN | period LINE_TILES: display only
module multiplane_tilemap_renderer #(
    parameter int NUM_PLANES      = 2,
    parameter int ADDR_PINS       = 4,
    parameter int DATA_PINS       = 4,
    parameter int RAM_LOG2_CYCLES = 2,
    parameter int TRANS_DELAY     = 2,
    parameter int LOG2_TILESIZE   = 3,
    parameter int COLOR_BITS      = 2,
    parameter int TMAP_X_BITS     = 6,
    parameter int TMAP_Y_BITS     = 5,
    parameter int Y_BITS          = 8,
    parameter int LINE_TILES      = 40,
    localparam int RC             = 1 << RAM_LOG2_CYCLES,
    localparam int TS             = 1 << LOG2_TILESIZE,
    localparam int AW             = ADDR_PINS * RC,
    localparam int DW             = DATA_PINS * RC,
    localparam int MB             = AW - TMAP_X_BITS - TMAP_Y_BITS,
    localparam int PIX_W          = NUM_PLANES * COLOR_BITS
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            line_start,
    input  logic [Y_BITS-1:0]               y,
    input  logic [NUM_PLANES*TMAP_X_BITS-1:0] scroll_x,
    input  logic [NUM_PLANES*Y_BITS-1:0]    scroll_y,
    input  logic [NUM_PLANES*MB-1:0]        map_base,
    multiplane_tilemap_renderer_if.master   bus
);
    localparam int TIW = AW - LOG2_TILESIZE;
    localparam int PW  = $clog2(LINE_TILES + 1);

    if (DW != TS * COLOR_BITS || 2 * NUM_PLANES + 2 * TRANS_DELAY > TS) begin : g_bad_cfg
        $error("multiplane_tilemap_renderer: row width or slot budget mismatch");
    end

    typedef enum logic [1:0] {IDLE, FETCH, RUN, DRAIN} state_t;

    state_t                     state_q, state_d;
    logic                       pend_q, pend_d;
    logic [RAM_LOG2_CYCLES-1:0] sub_q, sub_d;
    logic [LOG2_TILESIZE-1:0]   slot_q, slot_d;
    logic [PW-1:0]              period_q, period_d;

    logic            fetching, slot_end, period_end;
    logic [Y_BITS-1:0] v [NUM_PLANES];
    logic [AW-1:0]   map_addr [NUM_PLANES];
    logic [AW-1:0]   tile_addr [NUM_PLANES];
    logic [AW-1:0]   addr_word;
    logic [DW-1:0]   rx_q, rx_d, rx_word;
    logic [TIW-1:0]  tile_id_q [NUM_PLANES], tile_id_d [NUM_PLANES];
    logic [DW-1:0]   row_q [NUM_PLANES], row_d [NUM_PLANES];
    logic [DW-1:0]   shadow_q [NUM_PLANES], shadow_d [NUM_PLANES];
    logic [PIX_W-1:0] pixel_q, pixel_d;

    // The cycle after line_start is a pending cycle; counters start at the next edge.
    assign fetching   = (state_q == FETCH || state_q == RUN) && !pend_q;
    assign slot_end   = (sub_q == RAM_LOG2_CYCLES'(RC - 1));
    assign period_end = slot_end && (slot_q == LOG2_TILESIZE'(TS - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            pend_q   <= 1'b0;
            sub_q    <= '0;
            slot_q   <= '0;
            period_q <= '0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            sub_q    <= sub_d;
            slot_q   <= slot_d;
            period_q <= period_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        sub_d    = sub_q;
        slot_d   = slot_q;
        period_d = period_q;
        if (line_start) begin
            state_d  = FETCH;
            pend_d   = 1'b1;
            sub_d    = '0;
            slot_d   = '0;
            period_d = '0;
        end else if (state_q != IDLE) begin
            if (pend_q) begin
                pend_d = 1'b0;
            end else begin
                sub_d = sub_q + 1'b1;
                if (slot_end) begin
                    slot_d = slot_q + 1'b1;
                    if (period_end) begin
                        period_d = period_q + 1'b1;
                        unique case (state_q)
                            FETCH:   state_d = (LINE_TILES > 1) ? RUN : DRAIN;
                            RUN:     if (period_q == PW'(LINE_TILES - 1)) state_d = DRAIN;
                            DRAIN:   state_d = IDLE;
                            default: state_d = IDLE;
                        endcase
                    end
                end
            end
        end
    end

    always_comb begin
        bus.addr_bits   = '0;
        bus.pixel_valid = 1'b0;
        if (fetching) bus.addr_bits = addr_word[int'(sub_q)*ADDR_PINS +: ADDR_PINS];
        if (state_q == RUN || state_q == DRAIN) bus.pixel_valid = 1'b1;
    end

`ifdef MULTIPLANE_TILEMAP_TRANSPARENCY_EN
    localparam int PIW = (NUM_PLANES > 1) ? $clog2(NUM_PLANES) : 1;
    logic [COLOR_BITS-1:0] col;
`endif

    always_comb begin
        addr_word = '0;
        for (int p = 0; p < NUM_PLANES; p++) begin
            v[p] = y + scroll_y[p*Y_BITS +: Y_BITS];
            map_addr[p] = {map_base[p*MB +: MB],
                           TMAP_Y_BITS'(v[p] >> LOG2_TILESIZE),
                           TMAP_X_BITS'(period_q) + scroll_x[p*TMAP_X_BITS +: TMAP_X_BITS]};
            tile_addr[p] = {tile_id_q[p], v[p][LOG2_TILESIZE-1:0]};
            if (int'(slot_q) == p) addr_word = map_addr[p];
            if (int'(slot_q) == NUM_PLANES + TRANS_DELAY + p) addr_word = tile_addr[p];
        end

        // Current nibble merged in so the final subcycle yields the whole word.
        rx_word = rx_q;
        rx_word[int'(sub_q)*DATA_PINS +: DATA_PINS] = bus.data_bits;
        rx_d = fetching ? rx_word : rx_q;

        tile_id_d = tile_id_q;
        row_d     = row_q;
        shadow_d  = shadow_q;
        for (int p = 0; p < NUM_PLANES; p++) begin
            if (fetching && slot_end && int'(slot_q) == p + TRANS_DELAY)
                tile_id_d[p] = rx_word[TIW-1:0];
            if (fetching && slot_end && int'(slot_q) == NUM_PLANES + 2*TRANS_DELAY + p)
                row_d[p] = rx_word;
            // Last plane's row lands on the period-end edge, so copy the next value.
            if (fetching && period_end) shadow_d[p] = row_d[p];
            if (line_start) row_d[p] = '0;
        end

        pixel_d = '0;
`ifdef MULTIPLANE_TILEMAP_TRANSPARENCY_EN
        col = '0;
        if (state_d == RUN || state_d == DRAIN) begin
            // Walk downward so the lowest opaque plane is the last writer.
            for (int p = NUM_PLANES - 1; p >= 0; p--) begin
                col = shadow_d[p][int'(slot_d)*COLOR_BITS +: COLOR_BITS];
                if (col != '0) pixel_d = PIX_W'({PIW'(p), col});
            end
        end
`else
        if (state_d == RUN || state_d == DRAIN) begin
            for (int p = 0; p < NUM_PLANES; p++)
                pixel_d[p*COLOR_BITS +: COLOR_BITS] = shadow_d[p][int'(slot_d)*COLOR_BITS +: COLOR_BITS];
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_q    <= '0;
            pixel_q <= '0;
            for (int p = 0; p < NUM_PLANES; p++) begin
                tile_id_q[p] <= '0;
                row_q[p]     <= '0;
                shadow_q[p]  <= '0;
            end
        end else begin
            rx_q    <= rx_d;
            pixel_q <= pixel_d;
            for (int p = 0; p < NUM_PLANES; p++) begin
                tile_id_q[p] <= tile_id_d[p];
                row_q[p]     <= row_d[p];
                shadow_q[p]  <= shadow_d[p];
            end
        end
    end

    assign bus.pixel_out = pixel_q;

endmodule

// File: tb/tb_multiplane_tilemap_renderer.sv
// Directed bench for multiplane_tilemap_renderer at default parameters
// (AW = 16, MB = 5). A slot-indexed response table stands in for the RAM.
module tb_multiplane_tilemap_renderer;
    logic        clk;
    logic        reset;
    logic        line_start;
    logic [7:0]  y;
    logic [11:0] scroll_x;
    logic [15:0] scroll_y;
    logic [9:0]  map_base;

    multiplane_tilemap_renderer_if #(.ADDR_PINS(4), .DATA_PINS(4), .PIX_W(4)) bus ();

    multiplane_tilemap_renderer dut (
        .clk        (clk),
        .reset      (reset),
        .line_start (line_start),
        .y          (y),
        .scroll_x   (scroll_x),
        .scroll_y   (scroll_y),
        .map_base   (map_base),
        .bus        (bus)
    );

`ifdef MULTIPLANE_TILEMAP_TRANSPARENCY_EN
    localparam logic [3:0] EXP_A = 4'b0111;
`else
    localparam logic [3:0] EXP_A = 4'b1100;
`endif

    int          n_checks = 0;
    int          n_errors = 0;
    int          pos, k, s, c;
    bit          act;
    logic [15:0] resp_tab [8];
    logic [15:0] exp_a0 [8];
    logic [3:0]  exp_b [8];
    logic [15:0] acc, slot_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s pos=%0d got=%0h exp=%0h", tag, pos, got, exp);
        end
    endtask

    // One clock; on return we sit at the negedge inside the new cycle.
    task automatic tick();
        logic        started;
        logic        rst_in;
        logic [15:0] w;
        started = line_start && !reset;
        rst_in  = reset;
        @(negedge clk);
        line_start = 1'b0;
        if (rst_in) act = 1'b0;
        if (started) begin
            act = 1'b1;
            pos = -1;
        end else if (act) begin
            pos++;
        end
        if (act && pos >= 0) begin
            k = pos % 4;
            s = (pos / 4) % 8;
            c = pos / 32;
            acc[k*4 +: 4] = bus.addr_bits;
            if (k == 3) slot_addr = acc;
            w = resp_tab[s];
            bus.data_bits = w[k*4 +: 4];
        end else begin
            k = 0; s = 0; c = -1;
            bus.data_bits = '0;
        end
    endtask

    task automatic pulse_start();
        line_start = 1'b1;
        tick();
        chk("pend_valid", 32'(bus.pixel_valid), 32'd0);
        chk("pend_addr", 32'(bus.addr_bits), 32'd0);
    endtask

    initial begin
        reset = 1'b1; line_start = 1'b0; y = '0; scroll_x = '0; scroll_y = '0;
        map_base = {5'd1, 5'd1}; bus.data_bits = '0; act = 1'b0;
        pos = 0; k = 0; s = 0; c = 0; acc = '0; slot_addr = '0;
        for (int i = 0; i < 8; i++) begin resp_tab[i] = '0; exp_a0[i] = '0; end
        exp_a0[1] = 16'h0800; exp_a0[4] = 16'h0028; exp_a0[5] = 16'h0048;
        for (int i = 0; i < 8; i++) exp_b[i] = 4'(3 - (i % 4));

        // Reset held while line_start pulses: nothing may start.
        for (int i = 0; i < 3; i++) begin
            line_start = (i != 1);
            tick();
            chk("rst_addr", 32'(bus.addr_bits), 32'd0);
            chk("rst_pix", 32'(bus.pixel_out), 32'd0);
            chk("rst_valid", 32'(bus.pixel_valid), 32'd0);
        end
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("idle_addr", 32'(bus.addr_bits), 32'd0);
            chk("idle_valid", 32'(bus.pixel_valid), 32'd0);
        end

        // Line A: plain fetch, then period 1 display.
        map_base = {5'd1, 5'd0};
        resp_tab[2] = 16'h0005; resp_tab[3] = 16'h0009;
        resp_tab[6] = 16'h0000; resp_tab[7] = 16'hFFFF;
        pulse_start();
        for (int n = 0; n < 64; n++) begin
            tick();
            if (c == 0) begin
                chk($sformatf("a_p0_addr_s%0d_k%0d", s, k), 32'(bus.addr_bits), 32'(exp_a0[s][k*4 +: 4]));
                if (k == 0) chk("a_p0_valid", 32'(bus.pixel_valid), 32'd0);
            end else begin
                chk("a_p1_pix", 32'(bus.pixel_out), 32'(EXP_A));
                if (k == 0) chk("a_p1_valid", 32'(bus.pixel_valid), 32'd1);
                if (k == 3 && s == 0) chk("a_p1_map0", 32'(slot_addr), 32'h0001);
                if (k == 3 && s == 1) chk("a_p1_map1", 32'(slot_addr), 32'h0801);
            end
        end
        for (int n = 0; n < 200 && pos < 173; n++) tick();
        chk("a_reach_p5", 32'(c), 32'd5);

        // Restart mid-line with new rows; run the whole line to IDLE.
        resp_tab[6] = 16'h1B1B; resp_tab[7] = 16'h0000;
        pulse_start();
        for (int n = 0; n < 1313; n++) begin
            tick();
            if (c == 0 && k == 0) chk("b_p0_valid", 32'(bus.pixel_valid), 32'd0);
            if (c == 1 && (k == 0 || k == 3)) chk($sformatf("b_p1_pix_s%0d", s), 32'(bus.pixel_out), 32'(exp_b[s]));
            if (c == 1 && k == 0) chk("b_p1_valid", 32'(bus.pixel_valid), 32'd1);
            if (c == 39 && k == 3 && s == 0) chk("b_p39_map0", 32'(slot_addr), 32'h0027);
            if (c == 40 && k == 1) chk("b_drain_addr", 32'(bus.addr_bits), 32'd0);
            if (c == 40 && k == 0 && s == 0) chk("b_drain_valid0", 32'(bus.pixel_valid), 32'd1);
            if (c == 40 && k == 3 && s == 7) begin
                chk("b_drain_valid7", 32'(bus.pixel_valid), 32'd1);
                chk("b_drain_pix7", 32'(bus.pixel_out), 32'd0);
            end
        end
        chk("b_end_pos", 32'(pos), 32'd1312);
        chk("b_end_valid", 32'(bus.pixel_valid), 32'd0);
        chk("b_end_addr", 32'(bus.addr_bits), 32'd0);
        chk("b_end_pix", 32'(bus.pixel_out), 32'd0);
        for (int n = 0; n < 8; n++) tick();

        // Line C: scroll wrap in x and y, then reset mid-line.
        y = 8'd1;
        scroll_x = {6'd0, 6'd63};
        scroll_y = {8'd10, 8'd255};
        resp_tab[6] = 16'h1234; resp_tab[7] = 16'h5678;
        pulse_start();
        for (int n = 0; n < 76; n++) begin
            tick();
            if (k == 3 && c == 0 && s == 0) chk("c_p0_map0", 32'(slot_addr), 32'h003F);
            if (k == 3 && c == 0 && s == 1) chk("c_p0_map1", 32'(slot_addr), 32'h0840);
            if (k == 3 && c == 0 && s == 4) chk("c_p0_tile0", 32'(slot_addr), 32'h0028);
            if (k == 3 && c == 0 && s == 5) chk("c_p0_tile1", 32'(slot_addr), 32'h004B);
            if (k == 3 && c == 1 && s == 0) chk("c_p1_map0", 32'(slot_addr), 32'h0000);
            if (k == 3 && c == 1 && s == 1) chk("c_p1_map1", 32'(slot_addr), 32'h0841);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("c_rst_pix", 32'(bus.pixel_out), 32'd0);
        for (int n = 0; n < 40; n++) begin
            tick();
            chk("c_rst_addr", 32'(bus.addr_bits), 32'd0);
            chk("c_rst_valid", 32'(bus.pixel_valid), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
